// File: rtl/cpu_control.sv
// Multi-cycle control sequencer between the instruction fetch unit and the datapath.
// Optional retired-instruction counter enabled by defining CPU_CONTROL_RETIRED_EN.
module cpu_control #(
  parameter int NUM_PROGS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [8:0]  inst,
  input  logic        cond_flag,
  input  logic        mem_ack,
  output logic        init,
  output logic        fetch_unit_en,
  output logic        branch,
  output logic        branchi,
  output logic        jump,
  output logic [5:0]  immediate,
  output logic [2:0]  alu_op,
  output logic [2:0]  rs,
  output logic [2:0]  rt,
  output logic        reg_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic [15:0] retired
);

  localparam int PW = $clog2(NUM_PROGS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FETCH, S_EXEC, S_MEMWAIT, S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [8:0]      ir_q, ir_d;
  logic [PW-1:0]   prog_cnt_q, prog_cnt_d;
  logic [2:0]      opcode;
  logic            is_halt, is_mem, progs_left;

  assign opcode     = ir_q[8:6];
  assign is_halt    = (opcode == 3'b000) && (ir_q[5:0] == 6'b111111);
  assign is_mem     = (opcode == 3'b101);
  assign progs_left = (prog_cnt_q < PW'(NUM_PROGS));

  assign immediate = ir_q[5:0];
  assign alu_op    = ir_q[8:6];
  assign rs        = ir_q[5:3];
  assign rt        = ir_q[2:0];

  // cond_flag and mem_ack act within the same cycle, so the strobes are decoded
  // from the registered state and ir rather than pre-computed a cycle early.
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    prog_cnt_d    = prog_cnt_q;
    init          = 1'b0;
    fetch_unit_en = 1'b0;
    branch        = 1'b0;
    branchi       = 1'b0;
    jump          = 1'b0;
    reg_we        = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && progs_left) state_d = S_INIT;
      end
      S_INIT: begin
        init       = 1'b1;
        busy       = 1'b1;
        prog_cnt_d = prog_cnt_q + 1'b1;
        state_d    = S_FETCH;
      end
      S_FETCH: begin
        busy    = 1'b1;
        ir_d    = inst;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        busy = 1'b1;
        if (is_halt) begin
          state_d = S_HALT;
        end else if (is_mem) begin
          mem_req = 1'b1;
          mem_we  = ir_q[5];
          state_d = S_MEMWAIT;
        end else begin
          fetch_unit_en = 1'b1;
          state_d       = S_FETCH;
          case (opcode)
            3'b001, 3'b010, 3'b011, 3'b100: reg_we = 1'b1;
            3'b110: branch = cond_flag;
            3'b111: begin
              if (ir_q[5]) begin
                branchi = 1'b1;
                jump    = 1'b1;
              end else begin
                branchi = (cond_flag == ir_q[4]);
              end
            end
            default: ;
          endcase
        end
      end
      S_MEMWAIT: begin
        busy   = 1'b1;
        mem_we = ir_q[5];
        if (mem_ack) begin
          fetch_unit_en = 1'b1;
          reg_we        = ~ir_q[5];
          state_d       = S_FETCH;
        end else begin
          mem_req = 1'b1;
        end
      end
      S_HALT: begin
        done = 1'b1;
        if (start && progs_left) state_d = S_INIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      prog_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      prog_cnt_q <= prog_cnt_d;
    end
  end

`ifdef CPU_CONTROL_RETIRED_EN
  logic [15:0] retired_q, retired_d;

  // An instruction retires when control leaves EXEC/MEMWAIT for FETCH, or on HALT.
  always_comb begin
    retired_d = retired_q;
    if (state_q == S_INIT)
      retired_d = '0;
    else if ((state_q == S_EXEC || state_q == S_MEMWAIT) &&
             (state_d == S_FETCH || state_d == S_HALT))
      retired_d = retired_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) retired_q <= '0;
    else        retired_q <= retired_d;
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_cpu_control.sv
// Directed scoreboard bench for cpu_control: expected output vectors are queued
// as each step is driven, then popped and compared against the DUT outputs.
module tb_cpu_control;

  logic        clk = 1'b0;
  logic        rst_n, start, cond_flag, mem_ack;
  logic [8:0]  inst;
  logic        init, fetch_unit_en, branch, branchi, jump, reg_we, mem_req, mem_we, busy, done;
  logic [5:0]  immediate;
  logic [2:0]  alu_op, rs, rt;
  logic [15:0] retired;

  cpu_control #(.NUM_PROGS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inst(inst), .cond_flag(cond_flag),
    .mem_ack(mem_ack), .init(init), .fetch_unit_en(fetch_unit_en), .branch(branch),
    .branchi(branchi), .jump(jump), .immediate(immediate), .alu_op(alu_op), .rs(rs),
    .rt(rt), .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we), .busy(busy),
    .done(done), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam logic [9:0] C_INIT = 10'b1000000000;
  localparam logic [9:0] C_FUE  = 10'b0100000000;
  localparam logic [9:0] C_BR   = 10'b0010000000;
  localparam logic [9:0] C_BRI  = 10'b0001000000;
  localparam logic [9:0] C_JMP  = 10'b0000100000;
  localparam logic [9:0] C_RWE  = 10'b0000010000;
  localparam logic [9:0] C_MREQ = 10'b0000001000;
  localparam logic [9:0] C_MWE  = 10'b0000000100;
  localparam logic [9:0] C_BUSY = 10'b0000000010;
  localparam logic [9:0] C_DONE = 10'b0000000001;
  localparam logic [8:0] HALT_I = 9'b000_111111;

  typedef struct {
    string       tag;
    logic [24:0] exp;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [8:0] ir_m;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [9:0] ctrl);
    exp_t        e;
    exp_t        got;
    logic [24:0] obs;
    e.tag = tag;
    e.exp = {ctrl, ir_m[8:6], ir_m[5:3], ir_m[2:0], ir_m[5:0]};
    sb.push_back(e);
    #1;
    obs = {init, fetch_unit_en, branch, branchi, jump, reg_we, mem_req, mem_we, busy, done,
           alu_op, rs, rt, immediate};
    got = sb.pop_front();
    checks++;
    assert (obs === got.exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", got.tag, obs, got.exp);
    end
  endtask

  function automatic logic [15:0] exp_ret(input int n);
`ifdef CPU_CONTROL_RETIRED_EN
    return 16'(n);
`else
    return 16'd0 & 16'(n);
`endif
  endfunction

  task automatic chk_ret(input string tag, input int n);
    logic [15:0] e;
    e = exp_ret(n);
    checks++;
    assert (retired === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, retired, e);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; inst = 9'h1FF; cond_flag = 1'b1; mem_ack = 1'b1;
    ir_m = '0;
    tick();
    chk("reset", '0);
    chk_ret("reset_retired", 0);
    rst_n = 1'b1; cond_flag = 1'b0; mem_ack = 1'b0;
    chk("idle", '0);

    // program 1: ALU op then HALT
    tick();
    chk("init1", C_INIT | C_BUSY);
    start = 1'b0;
    tick();
    chk("init_one_cycle", C_BUSY);
    inst = 9'b001_010_011;
    tick(); ir_m = 9'b001_010_011;
    chk("alu", C_FUE | C_RWE | C_BUSY);
    inst = HALT_I;
    tick();
    chk("fetch2", C_BUSY);
    tick(); ir_m = HALT_I;
    chk("halt_exec", C_BUSY);
    tick();
    chk("halt_p1", C_DONE);
    chk_ret("retired_p1", 2);

    // program 2: branches and memory ops
    start = 1'b1;
    tick();
    chk("init2", C_INIT | C_BUSY);
    tick();
    chk("start_ignored_fetch", C_BUSY);
    chk_ret("retired_clear", 0);
    start = 1'b0;
    inst = 9'b111_1_00101;
    tick(); ir_m = 9'b111_1_00101;
    chk("long_jump", C_FUE | C_BRI | C_JMP | C_BUSY);
    inst = 9'b111_0_1_1_010;
    tick();
    tick(); ir_m = 9'b111_0_1_1_010;
    cond_flag = 1'b1;
    chk("short_taken", C_FUE | C_BRI | C_BUSY);
    cond_flag = 1'b0;
    chk("short_not_taken", C_FUE | C_BUSY);
    inst = 9'b110_011_000;
    tick();
    tick(); ir_m = 9'b110_011_000;
    cond_flag = 1'b1;
    chk("abs_taken", C_FUE | C_BR | C_BUSY);
    cond_flag = 1'b0;
    chk("abs_not_taken", C_FUE | C_BUSY);
    inst = 9'b101_0_00111;
    tick();
    tick(); ir_m = 9'b101_0_00111;
    chk("load_req", C_MREQ | C_BUSY);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("load_wait", C_MREQ | C_BUSY);
    end
    tick();
    mem_ack = 1'b1;
    chk("load_ack", C_FUE | C_RWE | C_BUSY);
    inst = 9'b101_1_00000;
    tick();
    mem_ack = 1'b0;
    chk("fetch_after_load", C_BUSY);
    tick(); ir_m = 9'b101_1_00000;
    chk("store_req", C_MREQ | C_MWE | C_BUSY);
    mem_ack = 1'b1;
    tick();
    chk("store_ack_first", C_FUE | C_MWE | C_BUSY);
    inst = HALT_I;
    tick();
    mem_ack = 1'b0;
    tick(); ir_m = HALT_I;
    tick();
    chk("halt_p2", C_DONE);
    chk_ret("retired_p2", 6);

    // program 3 with start held high, then a fourth start that must be ignored
    start = 1'b1;
    tick();
    chk("init3", C_INIT | C_BUSY);
    tick();
    chk("start_held_busy", C_BUSY);
    tick();
    chk("halt_exec3", C_BUSY);
    tick();
    chk("halt_p3", C_DONE);
    chk_ret("retired_p3", 1);
    tick();
    chk("fourth_start_ignored", C_DONE);
    tick();
    chk("fourth_start_ignored2", C_DONE);
    start = 1'b0;

    // reset clears the program count; then abort from MEMWAIT
    rst_n = 1'b0;
    tick(); ir_m = '0;
    rst_n = 1'b1;
    chk("reset2", '0);
    start = 1'b1;
    tick();
    chk("init_after_reset", C_INIT | C_BUSY);
    start = 1'b0;
    inst = 9'b101_0_10101;
    tick();
    tick(); ir_m = 9'b101_0_10101;
    chk("load_req2", C_MREQ | C_BUSY);
    tick();
    chk("memwait2", C_MREQ | C_BUSY);
    rst_n = 1'b0;
    tick(); ir_m = '0;
    chk("reset_in_memwait", '0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_abort", '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
